// File: rtl/neuron_accumulator.sv
// Multiply-accumulate back end for one neural layer: consumes RAM read data, writes saturated neuron results.
// Optional NEURON_ACCUMULATOR_RELU_EN clamps negative results to zero after saturation.
module neuron_accumulator #(
   parameter int DATA_W = 8,
   parameter int ACC_W  = 24,
   parameter int FRAC   = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic [7:0]               Nk_in,
   input  logic [7:0]               Nk_out,
   input  logic signed [DATA_W-1:0] weight_data,
   input  logic signed [DATA_W-1:0] neuro_data,
   input  logic                     neuron_last,
   input  logic [7:0]               neuro_write_addr_in,
   output logic                     write_en,
   output logic [7:0]               write_addr,
   output logic [DATA_W-1:0]        write_data,
   output logic                     busy,
   output logic                     done
);

   typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

   localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

   state_t                    r_state, w_state_nxt;
   logic [7:0]                r_nk_in, r_nk_out, r_cnt, r_term;
   logic signed [ACC_W-1:0]   r_acc;
   logic                      r_last_d, r_dvld;
   logic [7:0]                r_waddr_d;
   logic                      r_wen;
   logic [7:0]                r_waddr;
   logic [DATA_W-1:0]         r_wdata;

   logic                      w_addr_vld, w_dvld, w_first, w_term_end, w_wr;
   logic signed [2*DATA_W-1:0] w_prod;
   logic signed [ACC_W-1:0]   w_prod_ext, w_acc_nxt, w_shift;
   logic [DATA_W-1:0]         w_sat;

   // Data arriving after the last neuron's write is in flight only; the count gate drops it.
   assign w_addr_vld = (r_state == RUN) && (r_cnt != r_nk_out);
   assign w_dvld     = r_dvld && w_addr_vld;
   assign w_first    = (r_term == 8'd0);
   assign w_term_end = r_last_d || (r_term == r_nk_in - 8'd1);
   assign w_wr       = w_dvld && r_last_d;

   assign w_prod     = $signed({{DATA_W{weight_data[DATA_W-1]}}, weight_data}) *
                       $signed({{DATA_W{neuro_data[DATA_W-1]}}, neuro_data});
   assign w_prod_ext = {{(ACC_W-2*DATA_W){w_prod[2*DATA_W-1]}}, w_prod};
   assign w_acc_nxt  = (w_first ? '0 : r_acc) + w_prod_ext;
   assign w_shift    = w_acc_nxt >>> FRAC;

   always_comb begin
      if (w_shift > SAT_MAX)      w_sat = SAT_MAX[DATA_W-1:0];
      else if (w_shift < SAT_MIN) w_sat = SAT_MIN[DATA_W-1:0];
      else                        w_sat = w_shift[DATA_W-1:0];
`ifdef NEURON_ACCUMULATOR_RELU_EN
      if (w_sat[DATA_W-1]) w_sat = '0;
`else
`endif
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (start) w_state_nxt = RUN;
         RUN:     if (r_cnt == r_nk_out) w_state_nxt = FLUSH;
         FLUSH:   w_state_nxt = DONE;
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= IDLE;
         r_nk_in   <= '0;
         r_nk_out  <= '0;
         r_cnt     <= '0;
         r_term    <= '0;
         r_acc     <= '0;
         r_last_d  <= 1'b0;
         r_waddr_d <= '0;
         r_dvld    <= 1'b0;
         r_wen     <= 1'b0;
         r_waddr   <= '0;
         r_wdata   <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_last_d  <= neuron_last;
         r_waddr_d <= neuro_write_addr_in;
         r_dvld    <= w_addr_vld;
         r_wen     <= w_wr;
         if (w_wr) begin
            r_waddr <= r_waddr_d;
            r_wdata <= w_sat;
            r_cnt   <= r_cnt + 8'd1;
         end
         if (w_dvld) begin
            r_acc  <= w_acc_nxt;
            r_term <= w_term_end ? 8'd0 : r_term + 8'd1;
         end
         if (r_state == IDLE && start) begin
            r_nk_in  <= Nk_in;
            r_nk_out <= Nk_out;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_term   <= '0;
         end
      end
   end

   assign write_en   = r_wen;
   assign write_addr = r_waddr;
   assign write_data = r_wdata;
   assign busy       = (r_state == RUN) || (r_state == FLUSH);
   assign done       = (r_state == DONE);

endmodule

// File: tb/tb_neuron_accumulator.sv
// Scoreboard bench: two accumulators (FRAC=0 and FRAC=4) share one address-generator model.
module tb_neuron_accumulator;
   localparam int DW = 8;
   localparam int AW = 24;

   logic clk = 1'b0;
   logic reset, start, nlast;
   logic [7:0] nk_in, nk_out, waddr_in;
   logic [DW-1:0] wd, nd;
   logic we0, we4, busy0, busy4, done0, done4;
   logic [7:0] wa0, wa4;
   logic [DW-1:0] wdat0, wdat4;

   always #5 clk = ~clk;

   neuron_accumulator #(.DATA_W(DW), .ACC_W(AW), .FRAC(0)) u0 (
      .clk(clk), .reset(reset), .start(start), .Nk_in(nk_in), .Nk_out(nk_out),
      .weight_data(wd), .neuro_data(nd), .neuron_last(nlast), .neuro_write_addr_in(waddr_in),
      .write_en(we0), .write_addr(wa0), .write_data(wdat0), .busy(busy0), .done(done0));

   neuron_accumulator #(.DATA_W(DW), .ACC_W(AW), .FRAC(4)) u4 (
      .clk(clk), .reset(reset), .start(start), .Nk_in(nk_in), .Nk_out(nk_out),
      .weight_data(wd), .neuro_data(nd), .neuron_last(nlast), .neuro_write_addr_in(waddr_in),
      .write_en(we4), .write_addr(wa4), .write_data(wdat4), .busy(busy4), .done(done4));

   typedef struct packed {logic [7:0] a; logic [DW-1:0] d;} exp_t;
   exp_t q0[$], q4[$];
   int w_q[$], x_q[$];
   int n_cmp = 0, n_err = 0;

   task automatic check(input string nm, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Neuron result from the arithmetic rules: wrap to ACC_W, arithmetic shift, clamp, optional ReLU.
   function automatic logic [DW-1:0] model(input longint sum, input int frac);
      longint s;
      s = sum & ((longint'(1) << AW) - 1);
      if (s >= (longint'(1) << (AW-1))) s = s - (longint'(1) << AW);
      s = s >>> frac;
      if (s > 127) s = 127;
      if (s < -128) s = -128;
`ifdef NEURON_ACCUMULATOR_RELU_EN
      if (s < 0) s = 0;
`endif
      return DW'(s);
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (we0) begin
         if (q0.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL wr0_unexpected: got write addr %0d data %0d, required none", wa0, $signed(wdat0));
         end else begin
            e = q0.pop_front();
            check("wr0_addr", longint'(wa0), longint'(e.a));
            check("wr0_data", longint'($signed(wdat0)), longint'($signed(e.d)));
         end
      end
      if (we4) begin
         if (q4.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL wr4_unexpected: got write addr %0d data %0d, required none", wa4, $signed(wdat4));
         end else begin
            e = q4.pop_front();
            check("wr4_addr", longint'(wa4), longint'(e.a));
            check("wr4_data", longint'($signed(wdat4)), longint'($signed(e.d)));
         end
      end
   end

   task automatic chk_zero(input string nm);
      check({nm, "_we0"}, longint'(we0), 0);     check({nm, "_we4"}, longint'(we4), 0);
      check({nm, "_wa0"}, longint'(wa0), 0);     check({nm, "_wa4"}, longint'(wa4), 0);
      check({nm, "_wd0"}, longint'(wdat0), 0);   check({nm, "_wd4"}, longint'(wdat4), 0);
      check({nm, "_busy0"}, longint'(busy0), 0); check({nm, "_busy4"}, longint'(busy4), 0);
      check({nm, "_done0"}, longint'(done0), 0); check({nm, "_done4"}, longint'(done4), 0);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
         nlast = 1'($urandom); waddr_in = 8'($urandom); wd = DW'($urandom); nd = DW'($urandom);
      end
   endtask

   // Generator model: address stage of term j in cycle j+1 after start, its RAM data in cycle j+2.
   task automatic run_layer(input int ni, input int no, input int base, input int rst_at, input int restart_at);
      int t, exp_done, j, d;
      longint sum;
      t = ni * no;
      for (int n = 0; n < no; n++) begin
         sum = 0;
         for (int k = 0; k < ni; k++) sum += longint'(w_q[n*ni+k]) * longint'(x_q[n*ni+k]);
         q0.push_back('{a: 8'(base + n), d: model(sum, 0)});
         q4.push_back('{a: 8'(base + n), d: model(sum, 4)});
      end
      exp_done = (no == 0) ? 3 : t + 4;
      @(posedge clk); #1;
      start = 1'b1; nk_in = 8'(ni); nk_out = 8'(no);
      @(posedge clk); #1;
      for (int c = 1; c <= exp_done + 3; c++) begin
         nk_in = 8'($urandom); nk_out = 8'($urandom);
         j = c - 1; d = c - 2;
         if (j < t) begin nlast = ((j % ni) == ni - 1); waddr_in = 8'(base + j / ni); end
         else begin nlast = 1'($urandom); waddr_in = 8'($urandom); end
         if (d >= 0 && d < t) begin wd = DW'(w_q[d]); nd = DW'(x_q[d]); end
         else begin wd = DW'($urandom); nd = DW'($urandom); end
         start = (c == restart_at);
         if (c == rst_at) begin
            reset = 1'b0; #1;
            chk_zero("midrst");
            q0.delete(); q4.delete();
            repeat (3) @(posedge clk);
            #1 reset = 1'b1;
            break;
         end
         check("busy0", longint'(busy0), longint'(c < exp_done));
         check("busy4", longint'(busy4), longint'(c < exp_done));
         check("done0", longint'(done0), longint'(c == exp_done));
         check("done4", longint'(done4), longint'(c == exp_done));
         @(posedge clk); #1;
      end
      start = 1'b0;
      check("drained", longint'(q0.size() + q4.size()), 0);
   endtask

   task automatic fill_rand(input int n);
      w_q.delete(); x_q.delete();
      for (int i = 0; i < n; i++) begin
         w_q.push_back(int'($urandom_range(0, 255)) - 128);
         x_q.push_back(int'($urandom_range(0, 255)) - 128);
      end
   endtask

   initial begin
      int ni, no;
      reset = 1'b0; start = 1'b0; nlast = 1'b0; nk_in = '0; nk_out = '0;
      waddr_in = '0; wd = '0; nd = '0;
      repeat (3) @(posedge clk);
      #1 chk_zero("rst");
      reset = 1'b1;
      idle(3);

      w_q = '{1, 2, 3};  x_q = '{4, 5, 6};
      run_layer(3, 1, 8'h20, 0, 0);
      idle(2);
      w_q = '{127, 127, 127, 127};  x_q = '{127, 127, 127, 127};
      run_layer(2, 2, 8'h40, 0, 0);
      idle(2);
      w_q = '{-2};  x_q = '{64};
      run_layer(1, 1, 8'h05, 0, 0);
      idle(2);
      w_q.delete(); x_q.delete();
      run_layer(3, 0, 8'h00, 0, 0);
      idle(2);
      fill_rand(12);
      run_layer(3, 4, 8'h10, 6, 0);
      idle(3);
      fill_rand(12);
      run_layer(3, 4, 8'h80, 0, 0);
      idle(2);
      fill_rand(6);
      run_layer(2, 3, 8'h60, 0, 2);
      idle(2);
      fill_rand(4);
      run_layer(1, 4, 8'hF0, 0, 0);

      for (int i = 0; i < 12; i++) begin
         ni = int'($urandom_range(1, 5));
         no = int'($urandom_range(0, 4));
         fill_rand(ni * no);
         run_layer(ni, no, int'($urandom_range(0, 250)), 0, 0);
         idle(int'($urandom_range(1, 4)));
      end

      idle(3);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, required completion within 200000 time units");
      $fatal(1);
   end

endmodule

// File: doc/neuron_accumulator.md
NEURON_ACCUMULATOR -- requirements
Module: neuron_accumulator

Interface
REQ-001 SHALL have parameter DATA_W, default 8, signed width of weight, neuron and result data.
REQ-002 SHALL have parameter ACC_W, default 24, signed accumulator width.
REQ-003 SHALL have parameter FRAC, default 4, number of fractional bits removed from the accumulator before output.
REQ-004 clk  in  1  single clock; all state SHALL change on its rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  single-cycle pulse, driven with the same pulse that loads the address generator.
REQ-007 Nk_in  in  8  inputs per neuron; sampled on start.
REQ-008 Nk_out  in  8  neurons in the layer; sampled on start.
REQ-009 weight_data  in  DATA_W  signed weight read from weight RAM.
REQ-010 neuro_data  in  DATA_W  signed activation read from neuron RAM.
REQ-011 neuron_last  in  1  generator's neuron_finished, aligned with the read addresses.
REQ-012 neuro_write_addr_in  in  8  generator's write address, aligned with the read addresses.
REQ-013 write_en  out  1  one-cycle neuron RAM write strobe.
REQ-014 write_addr  out  8  neuron RAM write address.
REQ-015 write_data  out  DATA_W  activated, saturated neuron result.
REQ-016 busy  out  1  high in states RUN and FLUSH.
REQ-017 done  out  1  one-cycle pulse when the layer is complete.

Function
REQ-018 Read RAMs SHALL be treated as 1-cycle latency: data at edge k+1 belongs to the addresses, neuron_last and neuro_write_addr_in presented at edge k.
REQ-019 neuron_last and neuro_write_addr_in SHALL be delayed one cycle internally, together with a valid bit, to align with the data.
REQ-020 The FSM SHALL have states IDLE, RUN, FLUSH and DONE.
REQ-021 IDLE->RUN on start: latch Nk_in and Nk_out, clear the accumulator and the neuron counter.
REQ-022 In RUN, the address-valid bit SHALL be high in every cycle after entry; data-valid SHALL be address-valid delayed by one cycle.
REQ-023 On each data-valid cycle: acc <= (first term of neuron ? 0 : acc) + weight_data*neuro_data.
REQ-024 Products SHALL be sign-extended to ACC_W; accumulator overflow wraps modulo 2^ACC_W.
REQ-025 When delayed neuron_last is high on a data-valid cycle, the next cycle SHALL assert write_en for exactly one cycle.
REQ-026 On that write cycle: write_addr = delayed neuro_write_addr_in; write_data = sat(final_acc >>> FRAC).
REQ-027 sat SHALL clamp to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
REQ-028 A neuron counter SHALL increment on each write; when it reaches Nk_out the FSM SHALL go RUN->FLUSH, and address-valid SHALL drop.
REQ-029 FLUSH SHALL last one cycle, discarding in-flight data, then go to DONE.
REQ-030 DONE SHALL assert done for one cycle, then go to IDLE.
REQ-031 Nk_in=1: every valid cycle is a last term; one write per cycle.
REQ-032 Nk_out=0: RUN->FLUSH on the first cycle, with no write_en.
REQ-033 Nk_in=0 is unsupported; behaviour is undefined.
REQ-034 start SHALL be ignored outside IDLE.
REQ-035 In IDLE, write_en SHALL be 0 and neuron_last SHALL be ignored.

Reset
REQ-036 Asserting reset (low) SHALL immediately force state IDLE and clear the accumulator, counters, latched Nk values and all pipeline valid bits.
REQ-037 While in reset: write_en, write_addr, write_data, busy and done SHALL be 0.
REQ-038 Reset mid-layer SHALL abort with no further writes; the next start begins a fresh layer.

Configuration
REQ-039 Macro NEURON_ACCUMULATOR_RELU_EN defined: after saturation, negative results SHALL be replaced by 0.
REQ-040 Macro NEURON_ACCUMULATOR_RELU_EN undefined: the signed saturated value SHALL be written unchanged.

Verification
REQ-041 Nk_in=3, Nk_out=1, FRAC=0, w={1,2,3}, x={4,5,6}, last on 3rd address -> one write_en, write_data=32, write_addr=base, then done pulse.
REQ-042 Nk_in=2, Nk_out=2, w={127,127}, x={127,127}, FRAC=4 -> both writes saturate to 127 at consecutive write addresses.
REQ-043 Nk_in=1, w=-2, x=64, FRAC=0 -> write_data=-128 without RELU_EN, 0 with RELU_EN.
REQ-044 Nk_out=0, start -> no write_en; done 3 cycles after start (RUN, FLUSH, DONE).
REQ-045 Reset pulled low during the 2nd neuron of a 4-neuron layer -> outputs 0 immediately; no write after release; new start -> correct full layer.
REQ-046 start re-pulsed while busy -> ignored; write count equals the original Nk_out.
